// File: rtl/shared_mem_arbiter_ctrl_if.sv
// Bundle of the three-core request bus and the single-port memory handshake.
// The arbiter uses the slave view; cores plus memory (or a bench) use the master view.
interface shared_mem_arbiter_ctrl_if #(
  parameter int AW = 16,
  parameter int DW = 32
);
  logic [2:0]      core_req;
  logic [2:0]      core_we;
  logic [3*AW-1:0] core_addr;
  logic [3*DW-1:0] core_wdata;
  logic [2:0]      core_gnt;
  logic [2:0]      core_done;
  logic [2:0]      core_err;
  logic [DW-1:0]   core_rdata;
  logic            mem_req;
  logic            mem_we;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic [DW-1:0]   mem_rdata;
  logic            mem_ack;

  modport slave (
    input  core_req, core_we, core_addr, core_wdata, mem_rdata, mem_ack,
    output core_gnt, core_done, core_err, core_rdata,
           mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output core_req, core_we, core_addr, core_wdata, mem_rdata, mem_ack,
    input  core_gnt, core_done, core_err, core_rdata,
           mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/shared_mem_arbiter_ctrl.sv
// Round-robin arbiter sequencing three cores onto one single-port memory,
// with a req/ack handshake, registered outputs and a no-ack timeout.
module shared_mem_arbiter_ctrl #(
  parameter int AW      = 16,
  parameter int DW      = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  shared_mem_arbiter_ctrl_if.slave bus
);

  localparam int             CW       = $clog2(TIMEOUT);
  localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2} state_t;

  typedef struct packed {
    state_t          state;
    logic [1:0]      last_ptr;
    logic [1:0]      winner;
    logic [CW-1:0]   cnt;
    logic [2:0]      gnt;
    logic [2:0]      done;
    logic [2:0]      err;
    logic [DW-1:0]   rdata;
    logic            mem_req;
    logic            mem_we;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
  } regs_t;

  regs_t      r, r_n;
  logic [1:0] win;

  // Walk from the lowest priority (last_ptr itself) up to last_ptr+1, so the
  // highest-priority requester is the one written last.
  function automatic logic [1:0] pick_winner(input logic [2:0] req, input logic [1:0] last);
    logic [2:0] sum;
    logic [1:0] cand;
    pick_winner = 2'd0;
    for (int k = 3; k >= 1; k--) begin
      sum  = {1'b0, last} + 3'(k);
      cand = (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
      if (req[cand]) pick_winner = cand;
    end
  endfunction

  assign win = pick_winner(bus.core_req, r.last_ptr);

  always_comb begin
    // NOTE: every field takes its held value first, so no branch can infer a latch.
    r_n = r;
    unique case (r.state)
      IDLE: begin
        r_n.gnt       = '0;
        r_n.done      = '0;
        r_n.err       = '0;
        r_n.rdata     = '0;
        r_n.mem_req   = 1'b0;
        r_n.mem_we    = 1'b0;
        r_n.mem_addr  = '0;
        r_n.mem_wdata = '0;
        r_n.cnt       = '0;
        if (|bus.core_req) begin
          r_n.state     = BUSY;
          r_n.winner    = win;
          r_n.gnt       = 3'b001 << win;
          r_n.mem_req   = 1'b1;
          r_n.mem_we    = bus.core_we[win];
          r_n.mem_addr  = bus.core_addr[win*AW +: AW];
          r_n.mem_wdata = bus.core_wdata[win*DW +: DW];
        end
      end
      BUSY: begin
        // An ack on the same edge the count expires still counts as success.
        if (bus.mem_ack) begin
          r_n.state   = RESP;
          r_n.rdata   = bus.mem_rdata;
          r_n.mem_req = 1'b0;
          r_n.done    = r.gnt;
          r_n.err     = '0;
        end else if (r.cnt == CNT_LAST) begin
          r_n.state   = RESP;
          r_n.rdata   = '0;
          r_n.mem_req = 1'b0;
          r_n.done    = r.gnt;
          r_n.err     = r.gnt;
        end else begin
          r_n.cnt = r.cnt + 1'b1;
        end
      end
      RESP: begin
        r_n.state     = IDLE;
        r_n.last_ptr  = r.winner;
        r_n.gnt       = '0;
        r_n.done      = '0;
        r_n.err       = '0;
        r_n.rdata     = '0;
        r_n.mem_we    = 1'b0;
        r_n.mem_addr  = '0;
        r_n.mem_wdata = '0;
      end
      default: r_n.state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state updates use non-blocking assignment so all registers sample together.
    if (rst) begin
      r <= '{state: IDLE, last_ptr: 2'd2, winner: 2'd0, cnt: '0,
             gnt: 3'b000, done: 3'b000, err: 3'b000, rdata: '0,
             mem_req: 1'b0, mem_we: 1'b0, mem_addr: '0, mem_wdata: '0};
    end else begin
      r <= r_n;
    end
  end

  assign bus.core_gnt   = r.gnt;
  assign bus.core_done  = r.done;
  assign bus.core_err   = r.err;
  assign bus.core_rdata = r.rdata;
  assign bus.mem_req    = r.mem_req;
  assign bus.mem_we     = r.mem_we;
  assign bus.mem_addr   = r.mem_addr;
  assign bus.mem_wdata  = r.mem_wdata;

endmodule

// File: doc/shared_mem_arbiter_ctrl.md
Name: shared_mem_arbiter_ctrl

Overview:
- Sequences access from three cores to one single-port shared memory.
- Grants one requester at a time using rotating (round-robin) priority from the last-served core, and holds the grant for the whole transaction.
- Drives a req/ack memory handshake, returns read data to the winner, and recovers from a non-responding memory with a timeout.
- Sits between the three core load/store units and the shared data memory.

Parameters:
- AW, 16, address width
- DW, 32, data width
- TIMEOUT, 16, maximum cycles in BUSY without mem_ack before abort (≥2)

Ports:
- clk  in  1  clock; all logic on posedge
- rst  in  1  reset, synchronous, active-high
- core_req  in  3  per-core request; bit i = core i
- core_we  in  3  per-core write enable (1 = write, 0 = read)
- core_addr  in  3*AW  core i address at bits [i*AW +: AW]
- core_wdata  in  3*DW  core i write data at bits [i*DW +: DW]
- core_gnt  out  3  one-hot grant, held for the transaction
- core_done  out  3  one-cycle completion pulse to the served core
- core_err  out  3  one-cycle timeout flag, coincident with core_done
- core_rdata  out  DW  read data, valid while core_done is high
- mem_req  out  1  memory request
- mem_we  out  1  memory write enable
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data, valid with mem_ack
- mem_ack  in  1  memory completion

Behaviour:
- Reset (rst=1 at posedge):
  - State = IDLE, last_ptr = 2, so core 0 has first priority.
  - All outputs are 0, and the timeout counter is 0.
- FSM states: IDLE, BUSY, RESP. All outputs are registered.
- IDLE:
  - If core_req != 0, pick the winner w. Search order is last_ptr+1, last_ptr+2, last_ptr+3 (mod 3); the first set bit wins.
  - Latch core_we[w], core_addr[w] and core_wdata[w] into mem_we, mem_addr and mem_wdata.
  - Set core_gnt = one-hot(w) and mem_req = 1, clear the counter, and go to BUSY.
  - If no request, stay in IDLE with all outputs 0.
- BUSY:
  - mem_req, mem_we, mem_addr, mem_wdata and core_gnt are held stable.
  - On mem_ack=1: capture mem_rdata into core_rdata (also on writes), drop mem_req, go to RESP with err_flag = 0.
  - Otherwise increment the counter. If it reaches TIMEOUT-1 with no ack: drop mem_req, go to RESP with err_flag = 1, and leave core_rdata = 0.
  - Changes on core_req, core_addr or core_wdata during BUSY are ignored.
- RESP:
  - core_done[w] = 1 for exactly one cycle, and core_err[w] = err_flag.
  - core_gnt clears, last_ptr = w, and the FSM returns to IDLE.
  - core_rdata returns to 0 the cycle after RESP.
- Latency:
  - Request seen in IDLE at edge N → core_gnt and mem_req high after edge N.
  - mem_ack sampled at edge M → core_done high after edge M, for one cycle.
  - Minimum 3 cycles per transaction, so at most one transaction in flight.
- Requester rule:
  - A core holds core_req until it samples its core_done.
  - It clears core_req on that same edge, so a core wanting back-to-back service re-asserts core_req one cycle later.
  - Requests seen in IDLE are always treated as new.
- Fairness: with all three requesting continuously, the service order is 0, 1, 2, 0, 1, 2…; no core waits more than 2 transactions.
- Simultaneous events:
  - mem_ack arriving on the same edge as the timeout is reached counts as success (err = 0).
  - mem_ack while not in BUSY is ignored.
- Reset mid-transaction (rst in BUSY or RESP):
  - Abort immediately: all outputs 0, no core_done, last_ptr = 2.
  - The memory side must tolerate mem_req being withdrawn.
- Only one bit of core_gnt, core_done and core_err may be high at any time.

Test Plan:
- Single read: core 1 requests addr 0x0040; mem_ack after 2 cycles with rdata 0xDEADBEEF → core_gnt = 3'b010, mem_addr = 0x0040, core_done = 3'b010 with core_rdata = 0xDEADBEEF, core_err = 0.
- Rotation: after reset, all three cores request continuously, with mem_ack 1 cycle after each mem_req → grant order 0, 1, 2, 0; each core_done is one cycle wide.
- Priority after service: core 2 served, then cores 0 and 2 request together → core 0 granted first.
- Write plus hold: core 0 writes 0x12345678 to 0x0100; core_addr and core_wdata change during BUSY → mem_addr and mem_wdata stay 0x0100 and 0x12345678 until ack.
- Timeout: core 2 request, mem_ack never asserted → mem_req drops after 16 cycles in BUSY; core_done[2] = 1, core_err[2] = 1, core_rdata = 0. Next request is served normally.
- Reset mid-BUSY: rst pulsed 3 cycles into BUSY → mem_req, core_gnt and core_done all 0 the next cycle. A subsequent request from all three cores is granted to core 0.
